// File: rtl/dummy_wb_fifo.sv
// Result buffer between the dummy coprocessor and the core writeback port: a circular FIFO of {tag, result}.
// The optional zero-latency bypass for an empty buffer is enabled by defining DUMMY_WB_FIFO_FALLTHROUGH_EN.
module dummy_wb_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter type         tag_t      = logic,
    localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  tag_t                  tag_i,
    input  logic [DATA_WIDTH-1:0] rd_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output tag_t                  tag_o,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic [CntW-1:0]       count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    tag_t                  tag_q  [DEPTH];
    tag_t                  tag_d  [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic not_full, not_empty;
    logic push, pop, wr_en;

    assign not_full  = (cnt_q != CntW'(DEPTH));
    assign not_empty = (cnt_q != '0);

    assign ready_o = not_full & ~flush_i;
    assign push    = valid_i & ready_o;
    assign pop     = not_empty & ~flush_i & ready_i;
    assign count_o = cnt_q;

`ifdef DUMMY_WB_FIFO_FALLTHROUGH_EN
    logic bypass;

    // An empty buffer forwards the input; a result consumed in the same cycle is never stored.
    assign bypass  = ~not_empty & ~flush_i;
    assign valid_o = (not_empty & ~flush_i) | (bypass & valid_i);
    assign rd_o    = bypass ? rd_i  : data_q[rd_ptr_q];
    assign tag_o   = bypass ? tag_i : tag_q[rd_ptr_q];
    assign wr_en   = push & ~(bypass & ready_i);
`else
    assign valid_o = not_empty & ~flush_i;
    assign rd_o    = data_q[rd_ptr_q];
    assign tag_o   = tag_q[rd_ptr_q];
    assign wr_en   = push;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) begin
                data_d[wr_ptr_q] = rd_i;
                tag_d[wr_ptr_q]  = tag_i;
                wr_ptr_d         = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: storage is reset too so the stale head seen on rd_o/tag_o after reset is zero.
            data_q   <= '{default: '0};
            tag_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the pre-edge values.
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dummy_wb_fifo.sv
// Self-checking bench for dummy_wb_fifo: a scoreboard queue records accepted results and checks them in order
// as they leave; each scenario task adds its own inline checks of occupancy and handshake outputs.
module tb_dummy_wb_fifo;

    localparam int unsigned DW   = 32;
    localparam int unsigned DEP  = 4;
    localparam int unsigned CW   = $clog2(DEP) + 1;
    typedef logic [7:0] tb_tag_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    tb_tag_t       tag_i;
    logic [DW-1:0] rd_i;
    logic          valid_o;
    logic          ready_i;
    tb_tag_t       tag_o;
    logic [DW-1:0] rd_o;
    logic [CW-1:0] count_o;

    int checks = 0;
    int errors = 0;
    logic [39:0] sb [$];

    dummy_wb_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP),
        .tag_t     (tb_tag_t)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tag_i  (tag_i),
        .rd_i   (rd_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .tag_o  (tag_o),
        .rd_o   (rd_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle: sample the handshakes mid-cycle, update/compare the scoreboard, return just after the edge.
    task automatic tick();
        logic [39:0] exp;
        @(negedge clk_i);
        if (valid_i && ready_o) sb.push_back({tag_i, rd_i});
        if (valid_o && ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got tag %h rd %h, required no output", tag_o, rd_o);
            end else begin
                exp = sb.pop_front();
                if ({tag_o, rd_o} !== exp) begin
                    errors++;
                    $display("FAIL sb_order: got tag %h rd %h, required tag %h rd %h",
                             tag_o, rd_o, exp[39:32], exp[31:0]);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        tag_i   = '0;
        rd_i    = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({valid_o, ready_o, count_o, rd_o, tag_o} !== {1'b0, 1'b1, CW'(0), DW'(0), 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b ready %b count %0d rd %h tag %h, required 0 1 0 0 0",
                     valid_o, ready_o, count_o, rd_o, tag_o);
        end
        rst_ni = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_o, ready_o, count_o} !== {1'b0, 1'b1, CW'(0)}) begin
            errors++;
            $display("FAIL reset_idle: got valid %b ready %b count %0d, required 0 1 0", valid_o, ready_o, count_o);
        end
    endtask

    task automatic fill(input int n, input int base);
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tag_i = tb_tag_t'(base + i);
            rd_i  = DW'((base + i) * 16);
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic test_fill_drain();
        fill(4, 1);
        checks++;
        if (count_o !== CW'(4) || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got count %0d ready %b, required 4 0", count_o, ready_o);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (valid_o !== 1'b1 || rd_o !== DW'((i + 1) * 16)) begin
                errors++;
                $display("FAIL drain_seq%0d: got valid %b rd %h, required 1 %h", i, valid_o, rd_o, (i + 1) * 16);
            end
            tick();
        end
        checks++;
        if (count_o !== CW'(0) || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got count %0d valid %b, required 0 0", count_o, valid_o);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_full_pop_push();
        fill(4, 8'h11);
        valid_i = 1'b1;
        ready_i = 1'b1;
        tag_i   = 8'h55;
        rd_i    = 32'h50;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got ready %b, required 0", ready_o);
        end
        tick();
        checks++;
        if (count_o !== CW'(3) || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_only: got count %0d ready %b, required 3 1", count_o, ready_o);
        end
        ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        checks++;
        if (count_o !== CW'(4)) begin
            errors++;
            $display("FAIL full_repush: got count %0d, required 4", count_o);
        end
        ready_i = 1'b1;
        repeat (4) tick();
        ready_i = 1'b0;
        checks++;
        if (count_o !== CW'(0) || sb.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got count %0d pending %0d, required 0 0", count_o, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        fill(1, 8'h80);
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tag_i = tb_tag_t'(i);
            rd_i  = DW'(i);
            tick();
            checks++;
            if (count_o !== CW'(1)) begin
                errors++;
                $display("FAIL stream_count%0d: got %0d, required 1", i, count_o);
            end
        end
        valid_i = 1'b0;
        tick();
        ready_i = 1'b0;
        checks++;
        if (count_o !== CW'(0) || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_end: got count %0d pending %0d, required 0 0", count_o, sb.size());
        end
    endtask

    task automatic test_flush();
        fill(3, 8'hA0);
        valid_i = 1'b1;
        flush_i = 1'b1;
        tag_i   = 8'hEE;
        rd_i    = 32'hDEAD;
        #1;
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_hs: got ready %b valid %b, required 0 0", ready_o, valid_o);
        end
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        sb.delete();
        checks++;
        if (count_o !== CW'(0) || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got count %0d valid %b, required 0 0", count_o, valid_o);
        end
        ready_i = 1'b1;
        repeat (3) tick();
        fill(1, 8'hC0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        checks++;
        if (count_o !== CW'(0) || sb.size() != 0) begin
            errors++;
            $display("FAIL flush_reuse: got count %0d pending %0d, required 0 0", count_o, sb.size());
        end
    endtask

    task automatic test_latency();
        valid_i = 1'b1;
        ready_i = 1'b1;
        tag_i   = 8'h0A;
        rd_i    = 32'hAB;
        #1;
`ifdef DUMMY_WB_FIFO_FALLTHROUGH_EN
        checks++;
        if (valid_o !== 1'b1 || rd_o !== 32'hAB) begin
            errors++;
            $display("FAIL bypass_same_cycle: got valid %b rd %h, required 1 ab", valid_o, rd_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (count_o !== CW'(0)) begin
            errors++;
            $display("FAIL bypass_count: got %0d, required 0", count_o);
        end
`else
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_same_cycle: got valid %b, required 0", valid_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (count_o !== CW'(1) || valid_o !== 1'b1 || rd_o !== 32'hAB) begin
            errors++;
            $display("FAIL latency_next: got count %0d valid %b rd %h, required 1 1 ab", count_o, valid_o, rd_o);
        end
        tick();
        checks++;
        if (count_o !== CW'(0)) begin
            errors++;
            $display("FAIL latency_drain: got %0d, required 0", count_o);
        end
`endif
        ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        fill(2, 8'hD0);
        #2;
        rst_ni = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({valid_o, ready_o, count_o, rd_o} !== {1'b0, 1'b1, CW'(0), DW'(0)}) begin
            errors++;
            $display("FAIL async_reset: got valid %b ready %b count %0d rd %h, required 0 1 0 0",
                     valid_o, ready_o, count_o, rd_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pop_push();
        test_back_to_back();
        test_flush();
        test_latency();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
